memwb_stage_register: RTL and testbench

Parametrised MEM/WB pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and a write-back data select. It sits between the data-memory stage and the register-file write port, and replaces the free-running MEM/WB latch. Upstream and downstream can stall independently without losing or duplicating an instruction. A retire counter tracks committed register writes.

---
 rtl/memwb_pkg.sv | 24 ++
 rtl/memwb_payload_reg.sv | 22 ++
 rtl/memwb_stage_register.sv | 137 +++++++++++++
 tb/tb_memwb_stage_register.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB stage register: FSM state encoding and the
// payload record carried from the memory stage to register-file write-back.
package memwb_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } memwb_state_t;

  // 'do' is a reserved word, so the memory-data field is named mem_do.
  // The top re-declares this layout at its own parameter widths.
  typedef struct packed {
    logic                          wreg;
    logic                          m2reg;
    logic [REG_ADDR_W_DEFAULT-1:0] dest;
    logic [XLEN_DEFAULT-1:0]       r;
    logic [XLEN_DEFAULT-1:0]       mem_do;
  } memwb_payload_t;

endpackage

// File: rtl/memwb_payload_reg.sv
// Reset-to-zero payload register with load enable; one instance per slot.
module memwb_payload_reg
  import memwb_pkg::*;
#(
  parameter int unsigned W = $bits(memwb_payload_t)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memwb_stage_register.sv
// MEM/WB pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush, write-back data select and retired-write counter.
module memwb_stage_register #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wreg,
  input  logic                  in_m2reg,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [XLEN-1:0]       in_r,
  input  logic [XLEN-1:0]       in_do,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wreg,
  output logic                  out_m2reg,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [XLEN-1:0]       out_r,
  output logic [XLEN-1:0]       out_do,
  output logic [XLEN-1:0]       out_wdata,
  output logic [CNT_W-1:0]      retire_count
);

  import memwb_pkg::*;

  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       r;
    logic [XLEN-1:0]       mem_do;
  } payload_t;

  localparam int unsigned PW = $bits(payload_t);

  memwb_state_t   state_q, state_d;
  payload_t       in_p, main_q, skid_q, main_d;
  logic           main_load, skid_load;
  logic           in_ready_q, in_ready_d;
  logic           accept_in, accept_out;
  logic [CNT_W-1:0] retire_q;

  assign in_p = '{wreg: in_wreg, m2reg: in_m2reg, dest: in_dest, r: in_r, mem_do: in_do};

  assign accept_in  = in_valid & in_ready_q;
  assign accept_out = out_valid & out_ready;

  memwb_payload_reg #(.W(PW)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  memwb_payload_reg #(.W(PW)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .d     (in_p),
    .q     (skid_q)
  );

  // in_ready is registered alongside the state so it never depends on out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept_in) state_d = ONE;
        ONE: begin
          if (accept_in && !accept_out)      state_d = FULL;
          else if (!accept_in && accept_out) state_d = EMPTY;
        end
        FULL:    if (accept_out) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load  = 1'b0;
    skid_load  = 1'b0;
    main_d     = in_p;
    in_ready_d = (state_d != FULL);
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load = accept_in;
        ONE: begin
          main_load = accept_in & accept_out;
          skid_load = accept_in & ~accept_out;
        end
        FULL: begin
          main_load = accept_out;
          main_d    = skid_q;
        end
        default: ;
      endcase
    end
  end

  // A flush discards the main entry, so it is not counted even if WB is ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (accept_out && main_q.wreg && !flush) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign out_valid    = (state_q != EMPTY);
  assign in_ready     = in_ready_q;
  assign out_wreg     = main_q.wreg & out_valid;
  assign out_m2reg    = main_q.m2reg;
  assign out_dest     = main_q.dest;
  assign out_r        = main_q.r;
  assign out_do       = main_q.mem_do;
  assign out_wdata    = main_q.m2reg ? main_q.mem_do : main_q.r;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_memwb_stage_register.sv
// Bench for memwb_stage_register: directed vector table, hand sequences for
// async reset and counter wrap, then random traffic against a queue model.
module tb_memwb_stage_register;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_wreg, in_m2reg, out_ready;
  logic [4:0]  in_dest;
  logic [31:0] in_r, in_do;

  logic        in_ready, out_valid, out_wreg, out_m2reg;
  logic [4:0]  out_dest;
  logic [31:0] out_r, out_do, out_wdata, retire_count;

  logic        in_ready4, out_valid4, out_wreg4, out_m2reg4;
  logic [4:0]  out_dest4;
  logic [31:0] out_r4, out_do4, out_wdata4;
  logic [3:0]  retire_count4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  memwb_stage_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_m2reg(in_m2reg), .in_dest(in_dest),
    .in_r(in_r), .in_do(in_do),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wreg(out_wreg), .out_m2reg(out_m2reg), .out_dest(out_dest),
    .out_r(out_r), .out_do(out_do), .out_wdata(out_wdata),
    .retire_count(retire_count)
  );

  memwb_stage_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_wreg(in_wreg), .in_m2reg(in_m2reg), .in_dest(in_dest),
    .in_r(in_r), .in_do(in_do),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_wreg(out_wreg4), .out_m2reg(out_m2reg4), .out_dest(out_dest4),
    .out_r(out_r4), .out_do(out_do4), .out_wdata(out_wdata4),
    .retire_count(retire_count4)
  );

  // Reference model: an ordered list of held entries (at most two), the last
  // entry that occupied the head (outputs keep showing it), and a commit tally.
  typedef struct {
    logic        wreg;
    logic        m2reg;
    logic [4:0]  dest;
    logic [31:0] r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        last_main;
  logic [31:0] m_count;
  logic        m_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_main = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
    m_count   = '0;
    m_ready   = 1'b1;
  endtask

  task automatic model_step();
    logic ai;
    ai = in_valid && m_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) begin
        if (q[0].wreg) m_count = m_count + 32'd1;
        void'(q.pop_front());
      end
      if (ai) q.push_back('{in_wreg, in_m2reg, in_dest, in_r, in_do});
    end
    if (q.size() > 0) last_main = q[0];
    m_ready = (q.size() < 2);
  endtask

  task automatic check_model();
    logic        ev;
    logic [31:0] ew;
    ev = (q.size() > 0);
    ew = last_main.m2reg ? last_main.d : last_main.r;
    check("in_ready",     64'(in_ready),      64'(m_ready));
    check("out_valid",    64'(out_valid),     64'(ev));
    check("out_wreg",     64'(out_wreg),      64'(ev & last_main.wreg));
    check("out_m2reg",    64'(out_m2reg),     64'(last_main.m2reg));
    check("out_dest",     64'(out_dest),      64'(last_main.dest));
    check("out_r",        64'(out_r),         64'(last_main.r));
    check("out_do",       64'(out_do),        64'(last_main.d));
    check("out_wdata",    64'(out_wdata),     64'(ew));
    check("retire_count", 64'(retire_count),  64'(m_count));
    check("retire4",      64'(retire_count4), 64'(m_count[3:0]));
    check("out_valid4",   64'(out_valid4),    64'(ev));
    check("in_ready4",    64'(in_ready4),     64'(m_ready));
    check("out_wdata4",   64'(out_wdata4),    64'(ew));
  endtask

  // Inputs are driven right after a falling edge; the model advances at the
  // rising edge and outputs are compared on the next falling edge.
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model();
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic w,
                       input logic m2, input logic [31:0] r, input logic [31:0] d);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_wreg   = w;
    in_m2reg  = m2;
    in_dest   = 5'd5;
    in_r      = r;
    in_do     = d;
  endtask

  typedef struct {
    logic        iv, ordy, fl, wreg, m2reg;
    logic [31:0] r, d;
    logic        e_valid, e_ready, e_wreg;
    logic [31:0] e_wdata, e_count;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1,1,0, 1,0, 32'h1234, 32'h0,  1,1,1, 32'h1234, 32'd0};
    tbl[1]  = '{0,1,0, 0,0, 32'h0,    32'h0,  0,1,0, 32'h1234, 32'd1};
    tbl[2]  = '{1,1,0, 1,1, 32'h0,    32'hA0, 1,1,1, 32'hA0,   32'd1};
    tbl[3]  = '{1,1,0, 1,1, 32'h0,    32'hA1, 1,1,1, 32'hA1,   32'd2};
    tbl[4]  = '{1,1,0, 1,1, 32'h0,    32'hA2, 1,1,1, 32'hA2,   32'd3};
    tbl[5]  = '{1,1,0, 1,1, 32'h0,    32'hA3, 1,1,1, 32'hA3,   32'd4};
    tbl[6]  = '{0,1,0, 0,0, 32'h0,    32'h0,  0,1,0, 32'hA3,   32'd5};
    tbl[7]  = '{1,0,0, 1,1, 32'h0,    32'hB0, 1,1,1, 32'hB0,   32'd5};
    tbl[8]  = '{1,0,0, 1,1, 32'h0,    32'hB1, 1,0,1, 32'hB0,   32'd5};
    tbl[9]  = '{1,1,0, 1,1, 32'h0,    32'hB2, 1,1,1, 32'hB1,   32'd6};
    tbl[10] = '{1,1,0, 1,1, 32'h0,    32'hB2, 1,1,1, 32'hB2,   32'd7};
    tbl[11] = '{0,1,0, 0,0, 32'h0,    32'h0,  0,1,0, 32'hB2,   32'd8};
    tbl[12] = '{1,0,0, 1,1, 32'h0,    32'hB3, 1,1,1, 32'hB3,   32'd8};
    tbl[13] = '{1,0,0, 1,1, 32'h0,    32'hB4, 1,0,1, 32'hB3,   32'd8};
    tbl[14] = '{1,0,1, 1,1, 32'h0,    32'hB5, 0,1,0, 32'hB3,   32'd8};
    tbl[15] = '{1,1,0, 1,1, 32'h0,    32'hB6, 1,1,1, 32'hB6,   32'd8};
    tbl[16] = '{0,1,0, 0,0, 32'h0,    32'h0,  0,1,0, 32'hB6,   32'd9};
    tbl[17] = '{1,1,0, 0,0, 32'h55,   32'h0,  1,1,0, 32'h55,   32'd9};
    tbl[18] = '{0,1,0, 0,0, 32'h0,    32'h0,  0,1,0, 32'h55,   32'd9};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    check("rst_in_ready",  64'(in_ready),     64'(1));
    check("rst_out_valid", 64'(out_valid),    64'(0));
    check("rst_wdata",     64'(out_wdata),    64'(0));
    check("rst_count",     64'(retire_count), 64'(0));
    reset = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].wreg, tbl[i].m2reg, tbl[i].r, tbl[i].d);
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(out_valid),    64'(tbl[i].e_valid));
      check($sformatf("vec%0d_ready", i), 64'(in_ready),     64'(tbl[i].e_ready));
      check($sformatf("vec%0d_wreg", i),  64'(out_wreg),     64'(tbl[i].e_wreg));
      check($sformatf("vec%0d_wdata", i), 64'(out_wdata),    64'(tbl[i].e_wdata));
      check($sformatf("vec%0d_count", i), 64'(retire_count), 64'(tbl[i].e_count));
    end

    // Fill to FULL, then assert reset between clock edges.
    drive(1, 0, 0, 1, 0, 32'hC0, 32'hD0);
    cycle();
    drive(1, 0, 0, 1, 1, 32'hC1, 32'hD1);
    cycle();
    check("full_in_ready", 64'(in_ready), 64'(0));
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid),    64'(0));
    check("arst_in_ready",  64'(in_ready),     64'(1));
    check("arst_out_wreg",  64'(out_wreg),     64'(0));
    check("arst_wdata",     64'(out_wdata),    64'(0));
    check("arst_r",         64'(out_r),        64'(0));
    check("arst_do",        64'(out_do),       64'(0));
    check("arst_dest",      64'(out_dest),     64'(0));
    check("arst_m2reg",     64'(out_m2reg),    64'(0));
    check("arst_count",     64'(retire_count), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Seventeen committed writes: the 4-bit counter wraps to 1.
    for (int unsigned k = 0; k < 17; k++) begin
      drive(1, 1, 0, 1, 0, 32'h100 + k, 32'h0);
      cycle();
    end
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle();
    check("wrap_count32", 64'(retire_count),  64'(17));
    check("wrap_count4",  64'(retire_count4), 64'(1));

    for (int unsigned k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            1'($urandom), 1'($urandom), $urandom, $urandom);
      in_dest = 5'($urandom);
      if (flush) out_ready = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
